id_ex_stage: RTL and testbench

ID/EX pipeline register that sits directly upstream of the Alu. It captures decoded operands, the destination register and ALU_Sel from decode. It drives A, B and ALU_Sel into the Alu, forwarding results from the EX/MEM and MEM/WB stages. It uses a valid/ready handshake with stall hold, flush, and a saturating stall-cycle counter.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/fwd_sel.sv | 26 ++
 rtl/id_ex_stage.sv | 117 +++++++++++
 tb/tb_id_ex_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the decode -> ALU boundary: ALU op codes, default widths,
// and the field bundle held in the ID/EX pipeline register.
package alu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  // alu_sel stays a raw 4-bit field so undefined codes reach the ALU untouched
  typedef struct packed {
    logic [REG_AW_DEF-1:0] rs1_addr;
    logic [REG_AW_DEF-1:0] rs2_addr;
    logic [XLEN_DEF-1:0]   rs1_data;
    logic [XLEN_DEF-1:0]   rs2_data;
    logic [XLEN_DEF-1:0]   imm;
    logic                  use_imm;
    logic [3:0]            alu_sel;
    logic [REG_AW_DEF-1:0] rd;
    logic                  reg_write;
  } id_ex_t;

  // Register-file write/read collision: take the value being written this cycle
  function automatic logic [XLEN_DEF-1:0] wb_bypass(
    input logic [REG_AW_DEF-1:0] rs_addr,
    input logic [XLEN_DEF-1:0]   rf_data,
    input logic                  wb_en,
    input logic [REG_AW_DEF-1:0] wb_rd,
    input logic [XLEN_DEF-1:0]   wb_data
  );
    if (wb_en && (wb_rd == rs_addr) && (rs_addr != '0)) return wb_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding mux: EX/MEM beats MEM/WB beats stored value; x0 never forwarded.
// Latency: purely combinational. Backpressure: none.
module fwd_sel #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   st_data,
  input  logic              exm_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   operand
);

  always_comb begin
    operand = st_data;
    if (rs_addr != '0) begin
      if (exm_en && (exm_rd == rs_addr))    operand = exm_result;
      else if (wb_en && (wb_rd == rs_addr)) operand = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with operand forwarding and stall counting.
// Latency: 1 cycle capture. Backpressure: in_ready = !out_valid | out_ready; held data refreshed from forwarding.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [3:0]        in_alu_sel,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              exm_valid,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   A,
  output logic [XLEN-1:0]   B,
  output logic [3:0]        ALU_Sel,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic [CNT_W-1:0]  stall_cnt
);

  id_ex_t           st_q, st_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  fwd1, fwd2;
  logic             exm_en, wb_en, capture, hold;

  assign exm_en  = exm_valid & exm_reg_write;
  assign wb_en   = wb_valid & wb_reg_write;
  assign in_ready = ~vld_q | out_ready;
  assign capture = in_valid & in_ready & ~flush;
  assign hold    = vld_q & ~out_ready;

  fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr(st_q.rs1_addr), .st_data(st_q.rs1_data),
    .exm_en(exm_en), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(fwd1)
  );

  fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr(st_q.rs2_addr), .st_data(st_q.rs2_data),
    .exm_en(exm_en), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(fwd2)
  );

  always_comb begin
    st_d  = st_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (hold && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    if (flush) begin
      vld_d        = 1'b0;
      st_d.reg_write = 1'b0;
    end else if (capture) begin
      vld_d         = 1'b1;
      st_d.rs1_addr = in_rs1_addr;
      st_d.rs2_addr = in_rs2_addr;
      st_d.rs1_data = wb_bypass(in_rs1_addr, in_rs1_data, wb_en, wb_rd, wb_data);
      st_d.rs2_data = wb_bypass(in_rs2_addr, in_rs2_data, wb_en, wb_rd, wb_data);
      st_d.imm      = in_imm;
      st_d.use_imm  = in_use_imm;
      st_d.alu_sel  = in_alu_sel;
      st_d.rd       = in_rd;
      st_d.reg_write = in_reg_write;
    end else if (hold) begin
      // Latch forwarded values so they survive the producer leaving the pipe
      st_d.rs1_data = fwd1;
      st_d.rs2_data = fwd2;
    end else if (vld_q) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid     = vld_q;
  assign A             = vld_q ? fwd1 : '0;
  assign B             = vld_q ? (st_q.use_imm ? st_q.imm : fwd2) : '0;
  assign ALU_Sel       = st_q.alu_sel;
  assign out_rd        = st_q.rd;
  assign out_reg_write = st_q.reg_write;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plan steps followed by randomized traffic, checked against a behavioural model.
module tb_id_ex_stage;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm, in_reg_write;
  logic [3:0]  in_alu_sel;
  logic        flush;
  logic        exm_valid, exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] A, B;
  logic [3:0]  ALU_Sel;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [CW-1:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_sel(in_alu_sel),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .flush(flush),
    .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model of the pipeline slot
  logic        m_vld;
  logic [4:0]  m_a1, m_a2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;
  logic        m_use, m_rw;
  logic [3:0]  m_sel;
  int          m_cnt;

  function automatic logic [31:0] mfwd(input logic [4:0] a, input logic [31:0] d);
    if (a == 0) return d;
    if (exm_valid && exm_reg_write && exm_rd == a) return exm_result;
    if (wb_valid && wb_reg_write && wb_rd == a) return wb_data;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_a1 = 0; m_a2 = 0; m_rd = 0; m_d1 = 0; m_d2 = 0;
    m_imm = 0; m_use = 0; m_rw = 0; m_sel = 0; m_cnt = 0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0; in_rs2_data = 0;
    in_imm = 0; in_use_imm = 0; in_alu_sel = 0; in_rd = 0; in_reg_write = 0;
    flush = 0; exm_valid = 0; exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_valid = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic capture(input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] a2,
                         input logic [31:0] d2, input logic [3:0] sel);
    in_valid = 1; in_rs1_addr = a1; in_rs1_data = d1; in_rs2_addr = a2; in_rs2_data = d2;
    in_alu_sel = sel; in_rd = 5'd3; in_reg_write = 1;
  endtask

  // Compare every output with the model for the current cycle's inputs
  task automatic check_cycle();
    logic [31:0] ea, eb;
    #2;
    ea = m_vld ? mfwd(m_a1, m_d1) : 32'h0;
    eb = m_vld ? (m_use ? m_imm : mfwd(m_a2, m_d2)) : 32'h0;
    chk("in_ready", {31'h0, in_ready}, {31'h0, (!m_vld || out_ready)});
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_vld});
    chk("A", A, ea);
    chk("B", B, eb);
    chk("ALU_Sel", {28'h0, ALU_Sel}, {28'h0, m_sel});
    chk("out_rd", {27'h0, out_rd}, {27'h0, m_rd});
    chk("out_reg_write", {31'h0, out_reg_write}, {31'h0, m_rw});
    chk("stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, m_cnt);
  endtask

  task automatic advance();
    logic        rdy;
    logic [31:0] f1, f2;
    rdy = !m_vld || out_ready;
    f1 = mfwd(m_a1, m_d1);
    f2 = mfwd(m_a2, m_d2);
    if (m_vld && !out_ready && m_cnt < (1 << CW) - 1) m_cnt++;
    if (flush) begin
      m_vld = 0; m_rw = 0;
    end else if (in_valid && rdy) begin
      m_vld = 1; m_a1 = in_rs1_addr; m_a2 = in_rs2_addr;
      m_d1 = (wb_valid && wb_reg_write && wb_rd == in_rs1_addr && in_rs1_addr != 0) ? wb_data : in_rs1_data;
      m_d2 = (wb_valid && wb_reg_write && wb_rd == in_rs2_addr && in_rs2_addr != 0) ? wb_data : in_rs2_data;
      m_imm = in_imm; m_use = in_use_imm; m_sel = in_alu_sel; m_rd = in_rd; m_rw = in_reg_write;
    end else if (m_vld && !out_ready) begin
      m_d1 = f1; m_d2 = f2;
    end else begin
      m_vld = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    check_cycle();
    advance();
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    @(negedge clk);
    #2;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_A", A, 32'h0);
    chk("rst_B", B, 32'h0);
    chk("rst_ALU_Sel", {28'h0, ALU_Sel}, 32'h0);
    chk("rst_stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, 32'h0);
    @(negedge clk);
    rst = 0;

    // Plan 1: plain capture
    capture(5'd1, 32'h1, 5'd2, 32'h2, 4'b0010);
    step();
    idle_inputs();
    check_cycle();
    chk("p1_valid", {31'h0, out_valid}, 32'h1);
    chk("p1_A", A, 32'h1);
    chk("p1_B", B, 32'h2);
    chk("p1_sel", {28'h0, ALU_Sel}, 32'h2);
    advance();

    // Plan 2: EX/MEM priority over MEM/WB
    capture(5'd5, 32'h3, 5'd0, 32'h0, 4'b0110);
    step();
    idle_inputs();
    out_ready = 0;
    exm_valid = 1; exm_reg_write = 1; exm_rd = 5'd5; exm_result = 32'h7;
    wb_valid = 1; wb_reg_write = 1; wb_rd = 5'd5; wb_data = 32'h9;
    check_cycle();
    chk("p2_A_exm", A, 32'h7);
    exm_valid = 0;
    #1;
    chk("p2_A_wb", A, 32'h9);
    advance();
    idle_inputs();
    step();

    // Plan 3: hold refresh keeps forwarded value, stall counter counts
    do_reset();
    capture(5'd0, 32'h0, 5'd6, 32'h2, 4'b0010);
    step();
    idle_inputs();
    out_ready = 0;
    exm_valid = 1; exm_reg_write = 1; exm_rd = 5'd6; exm_result = 32'h7;
    check_cycle();
    chk("p3_B_fwd", B, 32'h7);
    chk("p3_cnt0", {{(32-CW){1'b0}}, stall_cnt}, 32'h0);
    advance();
    exm_valid = 0;
    check_cycle();
    chk("p3_B_held1", B, 32'h7);
    chk("p3_cnt1", {{(32-CW){1'b0}}, stall_cnt}, 32'h1);
    advance();
    check_cycle();
    chk("p3_B_held2", B, 32'h7);
    chk("p3_cnt2", {{(32-CW){1'b0}}, stall_cnt}, 32'h2);
    advance();
    out_ready = 1;
    step();

    // Plan 4: x0 guard, then capture-time WB bypass
    capture(5'd0, 32'h0, 5'd0, 32'h0, 4'b0000);
    step();
    idle_inputs();
    exm_valid = 1; exm_reg_write = 1; exm_rd = 5'd0; exm_result = 32'hFFFF_FFFF;
    check_cycle();
    chk("p4_A_x0", A, 32'h0);
    capture(5'd4, 32'h11, 5'd0, 32'h0, 4'b0001);
    exm_valid = 0;
    wb_valid = 1; wb_reg_write = 1; wb_rd = 5'd4; wb_data = 32'hAB;
    advance();
    idle_inputs();
    check_cycle();
    chk("p4_A_bypass", A, 32'hAB);
    advance();

    // Plan 5: immediate operand, then flush with an incoming instruction
    capture(5'd1, 32'h5, 5'd2, 32'h6, 4'b0111);
    in_use_imm = 1; in_imm = 32'h4;
    step();
    idle_inputs();
    out_ready = 0;
    check_cycle();
    chk("p5_B_imm", B, 32'h4);
    capture(5'd1, 32'h5, 5'd2, 32'h6, 4'b0111);
    flush = 1;
    advance();
    idle_inputs();
    check_cycle();
    chk("p5_flush_valid", {31'h0, out_valid}, 32'h0);
    chk("p5_flush_rw", {31'h0, out_reg_write}, 32'h0);
    advance();

    // Counter saturation
    capture(5'd1, 32'h1, 5'd2, 32'h2, 4'b1100);
    step();
    idle_inputs();
    out_ready = 0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", {{(32-CW){1'b0}}, stall_cnt}, (1 << CW) - 1);

    // Plan 6: async reset in the middle of a hold
    do_reset();
    capture(5'd1, 32'h21, 5'd2, 32'h22, 4'b0010);
    out_ready = 1;
    step();
    idle_inputs();
    out_ready = 0;
    step(); step(); step();
    chk("p6_cnt3", {{(32-CW){1'b0}}, stall_cnt}, 32'h3);
    #2;
    rst = 1;
    #1;
    chk("p6_valid", {31'h0, out_valid}, 32'h0);
    chk("p6_A", A, 32'h0);
    chk("p6_B", B, 32'h0);
    chk("p6_cnt", {{(32-CW){1'b0}}, stall_cnt}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 0;
    idle_inputs();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        in_valid = $urandom_range(0, 1);
        in_rs1_addr = $urandom_range(0, 7); in_rs2_addr = $urandom_range(0, 7);
        in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
        in_use_imm = $urandom_range(0, 1); in_alu_sel = $urandom_range(0, 15);
        in_rd = $urandom_range(0, 31); in_reg_write = $urandom_range(0, 1);
        flush = ($urandom_range(0, 7) == 0);
        exm_valid = $urandom_range(0, 1); exm_reg_write = $urandom_range(0, 1);
        exm_rd = $urandom_range(0, 7); exm_result = $urandom;
        wb_valid = $urandom_range(0, 1); wb_reg_write = $urandom_range(0, 1);
        wb_rd = $urandom_range(0, 7); wb_data = $urandom;
        out_ready = ($urandom_range(0, 2) != 0);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
